tlb_op_ctrl: RTL and testbench

Sequencer for the MIPS TLB management instructions (TLBP, TLBR, TLBWI, optionally TLBWR), placed between the writeback stage and the CP0 register file. It accepts one TLB op from WB, stalls the pipeline, and waits out the TLB lookup/read latency. It then pulses the matching op bit into CP0 in a single commit cycle and requests a refetch flush from PC+4, so that later instructions see the new mapping.

---
 rtl/cpu_defs.sv | 20 ++
 rtl/tlb_rand_idx.sv | 27 ++
 rtl/tlb_op_ctrl.sv | 133 +++++++++++++
 tb/tb_tlb_op_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: TLB op bit positions and the TLB op sequencer state type.
package cpu_defs;

  localparam int unsigned TLBOP_TLBP  = 0;
  localparam int unsigned TLBOP_TLBR  = 1;
  localparam int unsigned TLBOP_TLBWI = 2;
  localparam int unsigned TLBOP_TLBWR = 3;

  typedef logic [1:0] tlb_op_state_t;

  localparam tlb_op_state_t StIdle   = 2'd0;
  localparam tlb_op_state_t StWait   = 2'd1;
  localparam tlb_op_state_t StCommit = 2'd2;
  localparam tlb_op_state_t StFlush  = 2'd3;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/tlb_rand_idx.sv
// Free-running wrapping down-counter supplying the TLBWR random index.
module tlb_rand_idx #(
  parameter int unsigned Entries = 16,
  parameter int unsigned IdxW    = $clog2(Entries)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  output logic [IdxW-1:0] idx_o
);

  localparam logic [IdxW-1:0] MaxIdx = IdxW'(Entries - 1);

  logic [IdxW-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q - 1'b1;
    if (idx_q == '0) idx_d = MaxIdx;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) idx_q <= MaxIdx;
    else         idx_q <= idx_d;
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB management op sequencer between WB and CP0: stall, wait out TLB latency, commit, refetch.
// Optional TLBWR support is enabled by defining TLB_OP_CTRL_TLBWR_EN.
module tlb_op_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned TLB_LAT     = 1,
  parameter int unsigned TLB_ENTRIES = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           req_valid_i,
  input  logic [3:0]                     req_op_i,
  input  logic [31:0]                    req_pc_i,
  output logic                           req_ready_o,
  output logic                           stall_o,
  output logic [2:0]                     c0_tlb_op_o,
  output logic                           wr_idx_ovr_o,
  output logic [$clog2(TLB_ENTRIES)-1:0] wr_idx_o,
  output logic                           flush_o,
  output logic [31:0]                    flush_pc_o
);

  localparam int unsigned IdxW  = $clog2(TLB_ENTRIES);
  localparam logic [2:0]  LatM1 = 3'(TLB_LAT - 1);

`ifdef TLB_OP_CTRL_TLBWR_EN
  localparam logic WrEn = 1'b1;
`else
  localparam logic WrEn = 1'b0;
`endif

  tlb_op_state_t state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   pc_q, pc_d;
  logic          idle;
  logic          accept;
  logic          op_ok;
  logic          op_lookup;

  assign idle      = (state_q == StIdle);
  assign accept    = idle && req_valid_i;
  assign op_ok     = is_onehot4(req_op_i) && (WrEn || !req_op_i[TLBOP_TLBWR]);
  assign op_lookup = req_op_i[TLBOP_TLBP] || req_op_i[TLBOP_TLBR];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d = req_op_i;
          pc_d = req_pc_i;
          if (!op_ok) begin
            state_d = StFlush;
          end else if (op_lookup) begin
            state_d = StWait;
            cnt_d   = LatM1;
          end else begin
            state_d = StCommit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) state_d = StCommit;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StCommit: state_d = StFlush;
      StFlush:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      op_q    <= 4'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
    end
  end

`ifdef TLB_OP_CTRL_TLBWR_EN
  logic [IdxW-1:0] rand_idx;
  logic [IdxW-1:0] idx_q, idx_d;

  tlb_rand_idx #(
    .Entries (TLB_ENTRIES),
    .IdxW    (IdxW)
  ) u_rand_idx (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .idx_o   (rand_idx)
  );

  always_comb begin
    idx_d = idx_q;
    if (accept && req_op_i[TLBOP_TLBWR]) idx_d = rand_idx;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) idx_q <= '0;
    else         idx_q <= idx_d;
  end

  assign wr_idx_ovr_o = (state_q == StCommit) && op_q[TLBOP_TLBWR];
  assign wr_idx_o     = wr_idx_ovr_o ? idx_q : '0;
`else
  assign wr_idx_ovr_o = 1'b0;
  assign wr_idx_o     = '0;
`endif

  always_comb begin
    c0_tlb_op_o = 3'b000;
    // TLBWR commits to CP0 as a TLBWI with the index overridden.
    if (state_q == StCommit) begin
      c0_tlb_op_o = op_q[2:0] | {op_q[TLBOP_TLBWR], 2'b00};
    end
  end

  assign req_ready_o = idle;
  assign stall_o     = !idle || req_valid_i;
  assign flush_o     = (state_q == StFlush);
  assign flush_pc_o  = flush_o ? (pc_q + 32'd4) : 32'd0;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed self-checking bench for tlb_op_ctrl (TLB_LAT=2, TLB_ENTRIES=16).
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        stall;
  logic [2:0]  c0_tlb_op;
  logic        wr_idx_ovr;
  logic [3:0]  wr_idx;
  logic        flush;
  logic [31:0] flush_pc;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  tlb_op_ctrl #(
    .TLB_LAT     (2),
    .TLB_ENTRIES (16)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (req_valid),
    .req_op_i     (req_op),
    .req_pc_i     (req_pc),
    .req_ready_o  (req_ready),
    .stall_o      (stall),
    .c0_tlb_op_o  (c0_tlb_op),
    .wr_idx_ovr_o (wr_idx_ovr),
    .wr_idx_o     (wr_idx),
    .flush_o      (flush),
    .flush_pc_o   (flush_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to the middle of the next cycle; inputs change here, checks follow #1.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_pc    = 32'd0;
    nxt(); nxt();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_c0", 32'(c0_tlb_op), 32'd0);
    chk("rst_ovr", 32'(wr_idx_ovr), 32'd0);
    chk("rst_widx", 32'(wr_idx), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_fpc", flush_pc, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      chk("idle_ready", 32'(req_ready), 32'd1);
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_flush", 32'(flush), 32'd0);
      chk("idle_c0", 32'(c0_tlb_op), 32'd0);
    end

    // TLBWI at 0xBFC00100
    nxt();
    req_valid = 1'b1; req_op = 4'b0100; req_pc = 32'hBFC00100;
    #1;
    chk("wi_t_ready", 32'(req_ready), 32'd1);
    chk("wi_t_stall", 32'(stall), 32'd1);
    nxt();
    req_valid = 1'b0; req_op = 4'd0; req_pc = 32'd0;
    #1;
    chk("wi_t1_c0", 32'(c0_tlb_op), 32'b100);
    chk("wi_t1_flush", 32'(flush), 32'd0);
    chk("wi_t1_ovr", 32'(wr_idx_ovr), 32'd0);
    chk("wi_t1_ready", 32'(req_ready), 32'd0);
    chk("wi_t1_stall", 32'(stall), 32'd1);
    nxt(); #1;
    chk("wi_t2_flush", 32'(flush), 32'd1);
    chk("wi_t2_fpc", flush_pc, 32'hBFC00104);
    chk("wi_t2_c0", 32'(c0_tlb_op), 32'd0);
    nxt(); #1;
    chk("wi_t3_ready", 32'(req_ready), 32'd1);
    chk("wi_t3_stall", 32'(stall), 32'd0);
    chk("wi_t3_flush", 32'(flush), 32'd0);

    // TLBP with a second request (TLBWI) held from t+1
    nxt();
    req_valid = 1'b1; req_op = 4'b0001; req_pc = 32'h80000000;
    #1;
    chk("p_t_stall", 32'(stall), 32'd1);
    nxt();
    req_op = 4'b0100; req_pc = 32'h00001000;
    #1;
    chk("p_t1_c0", 32'(c0_tlb_op), 32'd0);
    chk("p_t1_stall", 32'(stall), 32'd1);
    chk("p_t1_ready", 32'(req_ready), 32'd0);
    nxt(); #1;
    chk("p_t2_c0", 32'(c0_tlb_op), 32'd0);
    chk("p_t2_stall", 32'(stall), 32'd1);
    chk("p_t2_flush", 32'(flush), 32'd0);
    nxt(); #1;
    chk("p_t3_c0", 32'(c0_tlb_op), 32'b001);
    chk("p_t3_flush", 32'(flush), 32'd0);
    chk("p_t3_stall", 32'(stall), 32'd1);
    nxt(); #1;
    chk("p_t4_flush", 32'(flush), 32'd1);
    chk("p_t4_fpc", flush_pc, 32'h80000004);
    chk("p_t4_c0", 32'(c0_tlb_op), 32'd0);
    chk("p_t4_ready", 32'(req_ready), 32'd0);
    nxt(); #1;
    chk("p_t5_ready", 32'(req_ready), 32'd1);
    chk("p_t5_flush", 32'(flush), 32'd0);
    nxt();
    req_valid = 1'b0; req_op = 4'd0; req_pc = 32'd0;
    #1;
    chk("p2_t1_c0", 32'(c0_tlb_op), 32'b100);
    nxt(); #1;
    chk("p2_t2_flush", 32'(flush), 32'd1);
    chk("p2_t2_fpc", flush_pc, 32'h00001004);
    nxt(); #1;
    chk("p2_t3_ready", 32'(req_ready), 32'd1);

    // Non-one-hot op at top of address space: flush only, pc wraps
    nxt();
    req_valid = 1'b1; req_op = 4'b0110; req_pc = 32'hFFFFFFFC;
    #1;
    chk("inv_t_stall", 32'(stall), 32'd1);
    nxt();
    req_valid = 1'b0; req_op = 4'd0; req_pc = 32'd0;
    #1;
    chk("inv_t1_c0", 32'(c0_tlb_op), 32'd0);
    chk("inv_t1_flush", 32'(flush), 32'd1);
    chk("inv_t1_fpc", flush_pc, 32'h00000000);
    nxt(); #1;
    chk("inv_t2_ready", 32'(req_ready), 32'd1);
    chk("inv_t2_c0", 32'(c0_tlb_op), 32'd0);

    // Zero op also goes straight to flush
    nxt();
    req_valid = 1'b1; req_op = 4'b0000; req_pc = 32'h00400010;
    nxt();
    req_valid = 1'b0; req_pc = 32'd0;
    #1;
    chk("zero_t1_c0", 32'(c0_tlb_op), 32'd0);
    chk("zero_t1_flush", 32'(flush), 32'd1);
    chk("zero_t1_fpc", flush_pc, 32'h00400014);

`ifdef TLB_OP_CTRL_TLBWR_EN
    // TLBWR 3 cycles after reset: random index 15-3 = 12
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;
    nxt(); nxt(); nxt();
    req_valid = 1'b1; req_op = 4'b1000; req_pc = 32'h00000200;
    nxt();
    req_valid = 1'b0; req_op = 4'd0;
    #1;
    chk("wr3_c0", 32'(c0_tlb_op), 32'b100);
    chk("wr3_ovr", 32'(wr_idx_ovr), 32'd1);
    chk("wr3_idx", 32'(wr_idx), 32'd12);
    nxt(); #1;
    chk("wr3_flush", 32'(flush), 32'd1);
    chk("wr3_ovr_off", 32'(wr_idx_ovr), 32'd0);

    // TLBWR 16 cycles after reset: index wrapped back to 15
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;
    for (int i = 0; i < 16; i++) nxt();
    req_valid = 1'b1; req_op = 4'b1000; req_pc = 32'h00000300;
    nxt();
    req_valid = 1'b0; req_op = 4'd0;
    #1;
    chk("wr16_c0", 32'(c0_tlb_op), 32'b100);
    chk("wr16_ovr", 32'(wr_idx_ovr), 32'd1);
    chk("wr16_idx", 32'(wr_idx), 32'd15);
    nxt(); #1;
    chk("wr16_fpc", flush_pc, 32'h00000304);
`else
    // TLBWR without support is an invalid op
    nxt();
    req_valid = 1'b1; req_op = 4'b1000; req_pc = 32'h00000200;
    nxt();
    req_valid = 1'b0; req_op = 4'd0;
    #1;
    chk("wrx_c0", 32'(c0_tlb_op), 32'd0);
    chk("wrx_flush", 32'(flush), 32'd1);
    chk("wrx_ovr", 32'(wr_idx_ovr), 32'd0);
    chk("wrx_fpc", flush_pc, 32'h00000204);
`endif

    // TLBR then reset at t+1: nothing pending survives
    nxt(); nxt();
    req_valid = 1'b1; req_op = 4'b0010; req_pc = 32'h00000800;
    nxt();
    req_valid = 1'b0; req_op = 4'd0;
    reset = 1'b1;
    #1;
    chk("rr_t1_stall", 32'(stall), 32'd1);
    nxt();
    reset = 1'b0;
    #1;
    chk("rr_t2_ready", 32'(req_ready), 32'd1);
    chk("rr_t2_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      chk("rr_c0", 32'(c0_tlb_op), 32'd0);
      chk("rr_flush", 32'(flush), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
